// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with access checks
module dmem_arbiter #(
    parameter int BUS_BITS  = 64,
    parameter int ADDR_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_0,
    input  logic                we_0,
    input  logic [BUS_BITS-1:0] addr_0,
    input  logic [2:0]          funct3_0,
    input  logic [BUS_BITS-1:0] wdata_0,
    output logic                gnt_0,
    output logic                done_0,
    output logic                err_0,
    output logic [BUS_BITS-1:0] rdata_0,

    input  logic                req_1,
    input  logic                we_1,
    input  logic [BUS_BITS-1:0] addr_1,
    input  logic [2:0]          funct3_1,
    input  logic [BUS_BITS-1:0] wdata_1,
    output logic                gnt_1,
    output logic                done_1,
    output logic                err_1,
    output logic [BUS_BITS-1:0] rdata_1,

    output logic                mem_we,
    output logic [BUS_BITS-1:0] mem_addr,
    output logic [2:0]          mem_funct3,
    output logic [BUS_BITS-1:0] mem_store_data,
    input  logic [BUS_BITS-1:0] mem_load_data
);

    // One past the last byte of memory, held one bit wider than the byte offset.
    localparam logic [ADDR_BITS:0] MEM_LIMIT = {1'b1, {ADDR_BITS{1'b0}}};

    logic last_winner;
    logic sel_1;
    logic any_gnt;
    logic illegal_0;
    logic illegal_1;
    logic win_we;
    logic win_illegal;

    // An access is rejected for a reserved size code, any address bit above the
    // implemented range, or a last byte that would run past the top of memory.
    function automatic logic access_illegal(input logic [BUS_BITS-1:0] addr,
                                            input logic [2:0]          funct3);
        logic [ADDR_BITS:0] size_bytes;
        logic [ADDR_BITS:0] end_addr;
        logic               high_bits;
        size_bytes = (ADDR_BITS+1)'(1) << funct3[1:0];
        end_addr   = {1'b0, addr[ADDR_BITS-1:0]} + size_bytes;
        high_bits  = |addr[BUS_BITS-1:ADDR_BITS];
        return (funct3 == 3'b111) || high_bits || (end_addr > MEM_LIMIT);
    endfunction

    assign illegal_0 = access_illegal(addr_0, funct3_0);
    assign illegal_1 = access_illegal(addr_1, funct3_1);

    // Pick the winner: a lone requester wins; under contention the previous loser wins.
    always_comb begin
        sel_1 = 1'b0;
        if (req_0 && req_1) begin
            sel_1 = (last_winner == 1'b0);
        end else begin
            sel_1 = req_1;
        end
    end

    assign gnt_0   = req_0 && !sel_1;
    assign gnt_1   = sel_1;
    assign any_gnt = gnt_0 || gnt_1;

    // Route the winner onto the memory port; port 0 drives it when nobody is granted.
    always_comb begin
        mem_addr       = addr_0;
        mem_funct3     = funct3_0;
        mem_store_data = wdata_0;
        win_we         = we_0;
        win_illegal    = illegal_0;
        if (gnt_1) begin
            mem_addr       = addr_1;
            mem_funct3     = funct3_1;
            mem_store_data = wdata_1;
            win_we         = we_1;
            win_illegal    = illegal_1;
        end
    end

    // Rejected stores are still granted but must never reach the memory.
    assign mem_we = any_gnt && win_we && !win_illegal;

    // Remember who won most recently; reset favours port 0 at first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= 1'b1;
        end else if (any_gnt) begin
            last_winner <= gnt_1;
        end
    end

    // Port 0 completion: pulse one cycle after grant with load data or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_0  <= 1'b0;
            err_0   <= 1'b0;
            rdata_0 <= '0;
        end else begin
            done_0 <= gnt_0;
            err_0  <= gnt_0 && illegal_0;
            if (gnt_0) begin
                rdata_0 <= (we_0 || illegal_0) ? '0 : mem_load_data;
            end
        end
    end

    // Port 1 completion: pulse one cycle after grant with load data or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_1  <= 1'b0;
            err_1   <= 1'b0;
            rdata_1 <= '0;
        end else begin
            done_1 <= gnt_1;
            err_1  <= gnt_1 && illegal_1;
            if (gnt_1) begin
                rdata_1 <= (we_1 || illegal_1) ? '0 : mem_load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int BB       = 64;
    localparam int AB       = 16;
    localparam int MEM_SIZE = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_0, we_0, req_1, we_1;
    logic [BB-1:0] addr_0, wdata_0, addr_1, wdata_1;
    logic [2:0]    funct3_0, funct3_1;
    logic          gnt_0, done_0, err_0, gnt_1, done_1, err_1;
    logic [BB-1:0] rdata_0, rdata_1;
    logic          mem_we;
    logic [BB-1:0] mem_addr, mem_store_data, mem_load_data;
    logic [2:0]    mem_funct3;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ram     [MEM_SIZE];
    logic [7:0] ref_mem [MEM_SIZE];

    always #5 clk = ~clk;

    dmem_arbiter #(.BUS_BITS(BB), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .funct3_0(funct3_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .done_0(done_0), .err_0(err_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .funct3_1(funct3_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .done_1(done_1), .err_1(err_1), .rdata_1(rdata_1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_funct3(mem_funct3),
        .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
    );

    function automatic logic [7:0] pat(int i);
        return 8'(i * 37 + (i >> 8) * 11 + 5);
    endfunction

    function automatic logic [63:0] extend(logic [63:0] raw, logic [2:0] f3);
        case (f3)
            3'd0:    return {{56{raw[7]}}, raw[7:0]};
            3'd1:    return {{48{raw[15]}}, raw[15:0]};
            3'd2:    return {{32{raw[31]}}, raw[31:0]};
            3'd4:    return {56'd0, raw[7:0]};
            3'd5:    return {48'd0, raw[15:0]};
            3'd6:    return {32'd0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory: combinational sized read with sign/zero extension.
    always_comb begin
        logic [63:0] raw;
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << mem_funct3[1:0])) begin
                raw[8*i +: 8] = ram[16'(mem_addr[15:0] + 16'(i))];
            end
        end
        mem_load_data = extend(raw, mem_funct3);
    end

    // Memory: the write seen mid-cycle is committed at the next rising edge.
    initial begin
        logic          w_en;
        logic [15:0]   w_a;
        logic [2:0]    w_f;
        logic [63:0]   w_d;
        for (int i = 0; i < MEM_SIZE; i++) ram[i] = pat(i);
        forever begin
            @(negedge clk);
            w_en = mem_we; w_a = mem_addr[15:0]; w_f = mem_funct3; w_d = mem_store_data;
            @(posedge clk);
            if (w_en) begin
                for (int i = 0; i < (1 << w_f[1:0]); i++) ram[16'(w_a + 16'(i))] = w_d[8*i +: 8];
            end
        end
    end

    // Reference model: predicts grant, memory port and completion outputs every cycle.
    initial begin
        int          lw;
        int          win;
        bit          ill;
        logic        pw;
        logic [63:0] pa, pd, raw;
        logic [2:0]  pf;
        bit          ed [2];
        bit          ee [2];
        logic [63:0] er [2];
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pat(i);
        lw = 1;
        for (int p = 0; p < 2; p++) begin ed[p] = 0; ee[p] = 0; er[p] = '0; end
        forever begin
            @(negedge clk);
            if (rst) begin
                lw = 1;
                for (int p = 0; p < 2; p++) begin ed[p] = 0; ee[p] = 0; er[p] = '0; end
            end
            chk("done_0", 64'(done_0), 64'(ed[0]));
            chk("err_0", 64'(err_0), 64'(ee[0]));
            chk("rdata_0", rdata_0, er[0]);
            chk("done_1", 64'(done_1), 64'(ed[1]));
            chk("err_1", 64'(err_1), 64'(ee[1]));
            chk("rdata_1", rdata_1, er[1]);
            if (!rst) begin
                win = -1;
                if (req_0 && req_1) win = 1 - lw;
                else if (req_0)     win = 0;
                else if (req_1)     win = 1;
                if (win >= 0) lw = win;
                if (win == 1) begin pw = we_1; pa = addr_1; pf = funct3_1; pd = wdata_1; end
                else          begin pw = we_0; pa = addr_0; pf = funct3_0; pd = wdata_0; end
                ill = (pf == 3'd7) || ((pa >> 16) != 0)
                      || (int'(pa[15:0]) + (1 << pf[1:0]) > MEM_SIZE);
                chk("gnt_0", 64'(gnt_0), 64'(win == 0));
                chk("gnt_1", 64'(gnt_1), 64'(win == 1));
                chk("mem_we", 64'(mem_we), 64'((win >= 0) && pw && !ill));
                chk("mem_addr", mem_addr, pa);
                chk("mem_funct3", 64'(mem_funct3), 64'(pf));
                chk("mem_store_data", mem_store_data, pd);
                raw = '0;
                if (!ill) begin
                    for (int i = 0; i < (1 << pf[1:0]); i++) raw[8*i +: 8] = ref_mem[int'(pa[15:0]) + i];
                end
                for (int p = 0; p < 2; p++) begin
                    ed[p] = (win == p);
                    ee[p] = (win == p) && ill;
                    if (win == p) er[p] = (ill || pw) ? 64'd0 : extend(raw, pf);
                end
                if (win >= 0 && pw && !ill) begin
                    for (int i = 0; i < (1 << pf[1:0]); i++) ref_mem[int'(pa[15:0]) + i] = pd[8*i +: 8];
                end
            end
        end
    end

    task automatic drive(int p, logic rq, logic w, logic [63:0] a, logic [2:0] f, logic [63:0] d);
        if (p == 0) begin req_0 = rq; we_0 = w; addr_0 = a; funct3_0 = f; wdata_0 = d; end
        else        begin req_1 = rq; we_1 = w; addr_1 = a; funct3_1 = f; wdata_1 = d; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // One isolated access with hand-computed completion values.
    task automatic single(int p, logic w, logic [63:0] a, logic [2:0] f, logic [63:0] d,
                          logic [63:0] exp_rdata, logic exp_err);
        step();
        drive(p, 1'b1, w, a, f, d);
        mid();
        chk("single_gnt", 64'(p == 0 ? gnt_0 : gnt_1), 64'd1);
        if (exp_err) chk("illegal_mem_we", 64'(mem_we), 64'd0);
        step();
        drive(p, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        mid();
        chk("single_done", 64'(p == 0 ? done_0 : done_1), 64'd1);
        chk("single_err", 64'(p == 0 ? err_0 : err_1), 64'(exp_err));
        chk("single_rdata", p == 0 ? rdata_0 : rdata_1, exp_rdata);
    endtask

    function automatic logic [63:0] rand_addr();
        int s;
        s = int'($urandom_range(0, 15));
        if (s < 11) return 64'(32'h10 + $urandom_range(0, 47));
        if (s < 14) return 64'(32'hFFF0 + $urandom_range(0, 15));
        if (s < 15) return 64'(32'h10000 + $urandom_range(0, 15));
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [2:0] rand_f3();
        int r;
        r = int'($urandom_range(0, 15));
        return (r == 15) ? 3'd7 : 3'(r % 7);
    endfunction

    initial begin
        bit act [2];
        bit gseen [2];
        int wc [2];
        int diffs;
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);

        // Reset state.
        repeat (3) mid();
        chk("reset_done_0", 64'(done_0), 64'd0);
        chk("reset_rdata_1", rdata_1, 64'd0);
        step();
        rst = 1'b0;

        // Continuous contention: 0,1,0,1,0,1 with done one cycle behind each grant.
        step();
        drive(0, 1'b1, 1'b0, 64'h40, 3'd3, 64'd0);
        drive(1, 1'b1, 1'b0, 64'h48, 3'd3, 64'd0);
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("contention_gnt_0", 64'(gnt_0), 64'(k % 2 == 0));
            chk("contention_gnt_1", 64'(gnt_1), 64'(k % 2 == 1));
            if (k > 0) chk("contention_done", 64'((k % 2 == 1) ? done_0 : done_1), 64'd1);
            if (k < 5) step();
        end
        step();
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        mid();
        chk("contention_last_done", 64'(done_1), 64'd1);

        // Doubleword store then load on port 0.
        single(0, 1'b1, 64'h100, 3'd3, 64'h1122334455667788, 64'd0, 1'b0);
        single(0, 1'b0, 64'h100, 3'd3, 64'd0, 64'h1122334455667788, 1'b0);

        // Reset while a granted load is in flight.
        step();
        drive(0, 1'b1, 1'b0, 64'h100, 3'd3, 64'd0);
        mid();
        chk("inflight_gnt_0", 64'(gnt_0), 64'd1);
        #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        #1;
        chk("reset_async_rdata_0", rdata_0, 64'd0);
        mid();
        chk("reset_dropped_done_0", 64'(done_0), 64'd0);
        step();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 64'h40, 3'd3, 64'd0);
        drive(1, 1'b1, 1'b0, 64'h48, 3'd3, 64'd0);
        mid();
        chk("post_reset_first_gnt_0", 64'(gnt_0), 64'd1);
        step();
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        mid();
        chk("post_reset_second_gnt_1", 64'(gnt_1), 64'd1);
        step();
        drive(1, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);

        // Store on port 1 is visible to a load on port 0 in the very next cycle.
        step();
        drive(1, 1'b1, 1'b1, 64'h10, 3'd0, 64'h80);
        mid();
        chk("sb_gnt_1", 64'(gnt_1), 64'd1);
        step();
        drive(1, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        drive(0, 1'b1, 1'b0, 64'h10, 3'd0, 64'd0);
        mid();
        chk("lb_gnt_0", 64'(gnt_0), 64'd1);
        chk("sb_done_1", 64'(done_1), 64'd1);
        step();
        drive(0, 1'b1, 1'b0, 64'h10, 3'd4, 64'd0);
        mid();
        chk("lb_rdata_0", rdata_0, 64'hFFFFFFFFFFFFFF80);
        step();
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        mid();
        chk("lbu_rdata_0", rdata_0, 64'h80);

        // Illegal accesses, then legal accesses right at the top of memory.
        single(0, 1'b0, 64'hFFFC, 3'd3, 64'd0, 64'd0, 1'b1);
        single(1, 1'b1, 64'h10000, 3'd2, 64'hDEADBEEF, 64'd0, 1'b1);
        single(0, 1'b1, 64'h20, 3'd7, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        single(1, 1'b1, 64'hFFF8, 3'd3, 64'hA5A5A5A5A5A5A5A5, 64'd0, 1'b0);
        single(0, 1'b0, 64'hFFF8, 3'd3, 64'd0, 64'hA5A5A5A5A5A5A5A5, 1'b0);
        single(1, 1'b0, 64'hFFFF, 3'd0, 64'd0, 64'hFFFFFFFFFFFFFFA5, 1'b0);

        // Randomized traffic under the hold-until-grant protocol.
        for (int p = 0; p < 2; p++) begin act[p] = 0; gseen[p] = 0; wc[p] = 0; end
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!act[p] || gseen[p]) begin
                    wc[p] = 0;
                    if ($urandom_range(0, 9) < 7) begin
                        act[p] = 1;
                        drive(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), rand_f3(),
                              {$urandom(), $urandom()});
                    end else begin
                        act[p] = 0;
                        drive(p, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
                    end
                end else begin
                    wc[p]++;
                end
            end
            mid();
            gseen[0] = gnt_0;
            gseen[1] = gnt_1;
            for (int p = 0; p < 2; p++) begin
                if (act[p]) chk("grant_wait_bound", 64'(wc[p] > 1), 64'd0);
            end
        end
        step();
        drive(0, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 3'd0, 64'd0);
        repeat (3) mid();

        diffs = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (ram[i] !== ref_mem[i]) diffs++;
        chk("memory_image", 64'(diffs), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
